// File: rtl/sdrc_mport_pkg.sv
// Shared types and constants for the Wishbone multi-port SDRAM front end.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sdrc_mport_pkg;

    // Arbitration modes selected by the ARB_MODE parameter of sdrc_wb_mport
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Transaction state machine
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        ACK   = 3'd4
    } state_t;

endpackage

// File: rtl/sdrc_rr_arb.sv
// Combinational one-hot port selector: round-robin from i_ptr, or fixed (lowest index wins).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is taken.
//
// Ports:
//   i_req   request vector, one bit per port
//   i_ptr   round-robin starting index (ignored when i_fixed = 1)
//   i_fixed 1 = fixed priority, 0 = round-robin
//   o_gnt   one-hot grant, zero when i_req is zero
module sdrc_rr_arb #(
    parameter int NPORT = 4,
    parameter int PW    = 2
) (
    input  logic [NPORT-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    input  logic             i_fixed,
    output logic [NPORT-1:0] o_gnt
);

    logic [PW-1:0]      w_start;
    logic [NPORT-1:0]   w_rot;
    logic [NPORT-1:0]   w_oh;
    logic [2*NPORT-1:0] w_gnt2;

    always_comb begin
        w_start = i_fixed ? '0 : i_ptr;
        // Rotate so the starting port sits at bit 0, pick the lowest set bit,
        // then rotate the one-hot result back into port numbering.
        w_rot   = NPORT'({i_req, i_req} >> w_start);
        w_oh    = w_rot & (~w_rot + NPORT'(1));
        w_gnt2  = {{NPORT{1'b0}}, w_oh} << w_start;
        o_gnt   = w_gnt2[NPORT-1:0] | w_gnt2[2*NPORT-1:NPORT];
    end

endmodule

// File: rtl/sdrc_wb_mport.sv
// Arbitrates NPORT Wishbone slave ports onto one single-beat SDRAM application request port.
// Latency: ack in the 4th cycle counting the strobe cycle (IDLE->REQ->WDATA/RDATA->ACK), zero app wait.
// Backpressure: stalls in REQ until app_req_ack, in WDATA until app_wr_next_req, in RDATA until app_rd_valid.
//
// Ports:
//   wb_clk_i / wb_rst_i               clock, synchronous active-high reset
//   wb_cyc_i/stb_i/we_i/addr_i/dat_i/sel_i  per-port Wishbone inputs, port p at slice [p*W +: W]
//   wb_ack_o / wb_dat_o               per-port ack, shared read data
//   app_req* / app_wr_* / app_rd_*    SDRAM controller application interface
//   grant_o / busy_o                  current owner (one-hot) and FSM-not-idle flag
module sdrc_wb_mport
    import sdrc_mport_pkg::*;
#(
    parameter int NPORT    = 4,
    parameter int APP_AW   = 26,
    parameter int dw       = 32,
    parameter int bl       = 9,
    parameter int ARB_MODE = 0
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NPORT-1:0]        wb_cyc_i,
    input  logic [NPORT-1:0]        wb_stb_i,
    input  logic [NPORT-1:0]        wb_we_i,
    input  logic [NPORT*APP_AW-1:0] wb_addr_i,
    input  logic [NPORT*dw-1:0]     wb_dat_i,
    input  logic [NPORT*dw/8-1:0]   wb_sel_i,
    output logic [NPORT-1:0]        wb_ack_o,
    output logic [dw-1:0]           wb_dat_o,
    output logic                    app_req,
    output logic [APP_AW-1:0]       app_req_addr,
    output logic [bl-1:0]           app_req_len,
    output logic                    app_req_wr_n,
    input  logic                    app_req_ack,
    input  logic                    app_wr_next_req,
    input  logic                    app_rd_valid,
    input  logic                    app_last_rd,
    input  logic [dw-1:0]           app_rd_data,
    output logic [dw-1:0]           app_wr_data,
    output logic [dw/8-1:0]         app_wr_en_n,
    output logic [NPORT-1:0]        grant_o,
    output logic                    busy_o
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int BW = dw / 8;

    state_t              r_state;
    state_t              w_next;
    logic [PW-1:0]       r_ptr;
    logic [NPORT-1:0]    r_grant;
    logic [PW-1:0]       r_gidx;
    logic [APP_AW-1:0]   r_addr;
    logic                r_we;
    logic [dw-1:0]       r_dat;
    logic [BW-1:0]       r_sel;
    logic [dw-1:0]       r_rdat;
    logic                r_drop;

    logic [NPORT-1:0]    w_req;
    logic [NPORT-1:0]    w_gnt;
    logic [PW-1:0]       w_gidx;
    logic [APP_AW-1:0]   w_addr;
    logic                w_we;
    logic [dw-1:0]       w_dat;
    logic [BW-1:0]       w_sel;
    logic                w_gcyc;
    logic                w_start;
    logic                w_clear;
    logic                w_set_drop;
    logic                w_ptr_upd;
    logic                w_rd_cap;

    // Every access is a single beat, so the last-read marker carries no information.
    logic                w_unused;
    assign w_unused = app_last_rd;

    assign w_req  = wb_cyc_i & wb_stb_i;
    // Owner still holding its cycle; used for abort and ack suppression.
    assign w_gcyc = |(r_grant & wb_cyc_i);

    sdrc_rr_arb #(
        .NPORT (NPORT),
        .PW    (PW)
    ) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .i_fixed (ARB_MODE == ARB_FIXED),
        .o_gnt   (w_gnt)
    );

    // Select the winning port's fields from the flattened buses.
    always_comb begin
        w_gidx = '0;
        w_addr = '0;
        w_we   = 1'b0;
        w_dat  = '0;
        w_sel  = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (w_gnt[i]) begin
                w_gidx = PW'(i);
                w_addr = wb_addr_i[i*APP_AW +: APP_AW];
                w_we   = wb_we_i[i];
                w_dat  = wb_dat_i[i*dw +: dw];
                w_sel  = wb_sel_i[i*BW +: BW];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_clear    = 1'b0;
        w_set_drop = 1'b0;
        w_ptr_upd  = 1'b0;
        w_rd_cap   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_start = 1'b1;
                    w_next  = REQ;
                end
            end
            REQ: begin
                // Once the controller has accepted, the access must run to
                // completion; only an un-accepted request can be withdrawn.
                if (app_req_ack) begin
                    w_next     = r_we ? WDATA : RDATA;
                    w_set_drop = ~w_gcyc;
                end else if (!w_gcyc) begin
                    w_next  = IDLE;
                    w_clear = 1'b1;
                end
            end
            WDATA: begin
                w_set_drop = ~w_gcyc;
                if (app_wr_next_req) begin
                    w_next    = ACK;
                    w_ptr_upd = 1'b1;
                end
            end
            RDATA: begin
                w_set_drop = ~w_gcyc;
                if (app_rd_valid) begin
                    w_next    = ACK;
                    w_ptr_upd = 1'b1;
                    w_rd_cap  = 1'b1;
                end
            end
            ACK: begin
                w_next  = IDLE;
                w_clear = 1'b1;
            end
            default: begin
                w_next  = IDLE;
                w_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_gidx  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_rdat  <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_start) begin
                r_grant <= w_gnt;
                r_gidx  <= w_gidx;
                r_addr  <= w_addr;
                r_we    <= w_we;
                r_dat   <= w_dat;
                r_sel   <= w_sel;
                r_drop  <= 1'b0;
            end
            if (w_clear) begin
                r_grant <= '0;
            end
            if (w_set_drop) begin
                r_drop <= 1'b1;
            end
            if (w_ptr_upd) begin
                r_ptr <= (r_gidx == PW'(NPORT - 1)) ? '0 : r_gidx + PW'(1);
            end
            if (w_rd_cap) begin
                r_rdat <= app_rd_data;
            end
        end
    end

    assign app_req      = (r_state == REQ);
    assign app_req_addr = r_addr;
    assign app_req_len  = bl'(1);
    assign app_req_wr_n = ~r_we;
    assign app_wr_data  = r_dat;
    assign app_wr_en_n  = (r_state == WDATA) ? ~r_sel : '1;
    assign wb_dat_o     = r_rdat;
    assign wb_ack_o     = (r_state == ACK && !r_drop && w_gcyc) ? r_grant : '0;
    assign grant_o      = r_grant;
    assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_sdrc_wb_mport.sv
// Directed bench for sdrc_wb_mport: one round-robin and one fixed-priority instance on shared stimulus.
// Latency: checks ack in the 4th cycle counting the strobe cycle.
// Backpressure: app-side handshakes are driven directly by the directed sequences.
module tb_sdrc_wb_mport;

    localparam int NP = 4;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int BL = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NP-1:0]    cyc = '0;
    logic [NP-1:0]    stb = '0;
    logic [NP-1:0]    we  = '0;
    logic [NP*AW-1:0] addr = '0;
    logic [NP*DW-1:0] wdat = '0;
    logic [NP*4-1:0]  sel  = '0;
    logic             app_ack  = 1'b0;
    logic             app_nxt  = 1'b0;
    logic             app_rv   = 1'b0;
    logic             app_last = 1'b0;
    logic [DW-1:0]    app_rdat = '0;

    logic [NP-1:0] rr_ack, rr_grant, fx_ack, fx_grant;
    logic [DW-1:0] rr_dat, rr_wdata, fx_dat, fx_wdata;
    logic          rr_req, rr_wrn, rr_busy, fx_req, fx_wrn, fx_busy;
    logic [AW-1:0] rr_addr, fx_addr;
    logic [BL-1:0] rr_len, fx_len;
    logic [3:0]    rr_en_n, fx_en_n;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sdrc_wb_mport #(.NPORT(NP), .APP_AW(AW), .dw(DW), .bl(BL), .ARB_MODE(0)) u_rr (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_addr_i(addr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_ack_o(rr_ack), .wb_dat_o(rr_dat),
        .app_req(rr_req), .app_req_addr(rr_addr), .app_req_len(rr_len), .app_req_wr_n(rr_wrn),
        .app_req_ack(app_ack), .app_wr_next_req(app_nxt), .app_rd_valid(app_rv),
        .app_last_rd(app_last), .app_rd_data(app_rdat), .app_wr_data(rr_wdata),
        .app_wr_en_n(rr_en_n), .grant_o(rr_grant), .busy_o(rr_busy)
    );

    sdrc_wb_mport #(.NPORT(NP), .APP_AW(AW), .dw(DW), .bl(BL), .ARB_MODE(1)) u_fx (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_addr_i(addr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_ack_o(fx_ack), .wb_dat_o(fx_dat),
        .app_req(fx_req), .app_req_addr(fx_addr), .app_req_len(fx_len), .app_req_wr_n(fx_wrn),
        .app_req_ack(app_ack), .app_wr_next_req(app_nxt), .app_rd_valid(app_rv),
        .app_last_rd(app_last), .app_rd_data(app_rdat), .app_wr_data(fx_wdata),
        .app_wr_en_n(fx_en_n), .grant_o(fx_grant), .busy_o(fx_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, input logic w);
        addr[p*AW +: AW] = a;
        wdat[p*DW +: DW] = d;
        sel[p*4 +: 4]    = s;
        we[p]            = w;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_busy"},  rr_busy,  0);
        chk({tag, "_grant"}, rr_grant, 0);
        chk({tag, "_ack"},   rr_ack,   0);
        chk({tag, "_dat"},   rr_dat,   0);
        chk({tag, "_req"},   rr_req,   0);
        chk({tag, "_addr"},  rr_addr,  0);
        chk({tag, "_len"},   rr_len,   1);
        chk({tag, "_wrn"},   rr_wrn,   1);
        chk({tag, "_wdata"}, rr_wdata, 0);
        chk({tag, "_en_n"},  rr_en_n,  4'hF);
    endtask

    task automatic do_reset();
        cyc = '0; stb = '0; app_ack = 0; app_nxt = 0; app_rv = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int seen;
        logic [NP-1:0] exp_g;

        // Reset state
        do_reset();
        check_reset_outs("rst");

        // Port 2 write, controller acks immediately
        set_port(2, 26'h0000100, 32'hA5A5_1234, 4'hF, 1'b1);
        cyc = 4'b0100; stb = 4'b0100; app_ack = 1; app_nxt = 1;
        tick();
        chk("wr_req", rr_req, 1);
        chk("wr_addr", rr_addr, 26'h0000100);
        chk("wr_wrn", rr_wrn, 0);
        chk("wr_grant", rr_grant, 4'b0100);
        chk("wr_en_n_req", rr_en_n, 4'hF);
        chk("wr_ack_c2", rr_ack, 0);
        tick();
        chk("wr_req_drop", rr_req, 0);
        chk("wr_en_n", rr_en_n, 4'h0);
        chk("wr_data", rr_wdata, 32'hA5A5_1234);
        chk("wr_ack_c3", rr_ack, 0);
        tick();
        chk("wr_ack_c4", rr_ack, 4'b0100);
        cyc = '0; stb = '0;
        tick();
        chk("wr_ack_once", rr_ack, 0);
        chk("wr_idle", rr_busy, 0);
        chk("wr_grant_idle", rr_grant, 0);

        // Port 0 read, data 3 cycles after the controller ack; stray next_req ignored
        app_ack = 0; app_nxt = 0;
        set_port(0, 26'h0002000, 32'h0, 4'hF, 1'b0);
        cyc = 4'b0001; stb = 4'b0001;
        tick();
        chk("rd_req", rr_req, 1);
        chk("rd_wrn", rr_wrn, 1);
        chk("rd_grant", rr_grant, 4'b0001);
        app_ack = 1;
        tick();
        app_ack = 0; app_nxt = 1;
        chk("rd_req_drop", rr_req, 0);
        tick();
        app_nxt = 0;
        chk("rd_wait_busy", rr_busy, 1);
        chk("rd_wait_ack", rr_ack, 0);
        chk("rd_wait_en_n", rr_en_n, 4'hF);
        tick();
        app_rv = 1; app_rdat = 32'hDEAD_BEEF;
        tick();
        app_rv = 0;
        chk("rd_ack", rr_ack, 4'b0001);
        chk("rd_dat", rr_dat, 32'hDEAD_BEEF);
        cyc = '0; stb = '0;
        tick();
        chk("rd_ack_once", rr_ack, 0);

        // Write with sel = 0 still issued, no bytes enabled
        set_port(1, 26'h0000040, 32'h1111_2222, 4'h0, 1'b1);
        cyc = 4'b0010; stb = 4'b0010; app_ack = 1; app_nxt = 1;
        tick();
        chk("sel0_wrn", rr_wrn, 0);
        tick();
        chk("sel0_en_n", rr_en_n, 4'hF);
        tick();
        chk("sel0_ack", rr_ack, 4'b0010);
        cyc = '0; stb = '0;
        tick();

        // Owner drops cyc after the controller ack: transfer completes, ack suppressed
        set_port(3, 26'h0000300, 32'h3333_3333, 4'hF, 1'b1);
        cyc = 4'b1000; stb = 4'b1000; app_ack = 1; app_nxt = 0;
        tick();
        tick();
        cyc = '0; stb = '0; app_nxt = 1;
        tick();
        chk("drop_busy_ack", rr_busy, 1);
        chk("drop_no_ack", rr_ack, 0);
        tick();
        chk("drop_idle", rr_busy, 0);

        // Owner withdraws in REQ before ack; pointer unchanged so port 1 wins again over port 2
        do_reset();
        set_port(1, 26'h0000111, 32'h0101_0101, 4'hF, 1'b1);
        set_port(2, 26'h0000222, 32'h0202_0202, 4'hF, 1'b1);
        cyc = 4'b0010; stb = 4'b0010; app_ack = 0; app_nxt = 0;
        tick();
        chk("abort_req", rr_req, 1);
        chk("abort_grant", rr_grant, 4'b0010);
        cyc = '0; stb = '0;
        tick();
        chk("abort_req_fall", rr_req, 0);
        chk("abort_busy", rr_busy, 0);
        chk("abort_ack", rr_ack, 0);
        cyc = 4'b0110; stb = 4'b0110; app_ack = 1; app_nxt = 1;
        tick();
        chk("abort_regrant", rr_grant, 4'b0010);
        tick();
        tick();
        chk("abort_ack_after", rr_ack, 4'b0010);
        cyc = '0; stb = '0;
        tick();

        // Round-robin with all four ports requesting continuously
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, AW'(32'h10 * (p + 1)), DW'(p), 4'hF, 1'b1);
        cyc = 4'hF; stb = 4'hF; app_ack = 1; app_nxt = 1;
        seen = 0;
        for (int t = 0; t < 40 && seen < 5; t++) begin
            tick();
            if (rr_req) begin
                exp_g = 4'b0001 << (seen % 4);
                chk("rr_grant", rr_grant, exp_g);
                chk("rr_addr", rr_addr, 32'h10 * ((seen % 4) + 1));
                seen++;
            end
        end
        chk("rr_seen", seen, 5);
        cyc = '0; stb = '0;
        tick();
        tick();
        tick();

        // Fixed priority with ports 1 and 3: port 1 first, then port 3
        do_reset();
        cyc = 4'b1010; stb = 4'b1010; app_ack = 1; app_nxt = 1;
        seen = 0;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (fx_req) begin
                exp_g = (seen == 0) ? 4'b0010 : 4'b1000;
                chk("fx_grant", fx_grant, exp_g);
                seen++;
            end
            if (fx_ack[1]) begin cyc[1] = 0; stb[1] = 0; end
            if (fx_ack[3]) begin cyc[3] = 0; stb[3] = 0; end
        end
        chk("fx_seen", seen, 2);

        // Reset during WDATA abandons the write
        do_reset();
        set_port(2, 26'h0000500, 32'h5555_AAAA, 4'hF, 1'b1);
        cyc = 4'b0100; stb = 4'b0100; app_ack = 1; app_nxt = 0;
        tick();
        tick();
        chk("rstw_en_n", rr_en_n, 4'h0);
        rst = 1; cyc = '0; stb = '0;
        tick();
        check_reset_outs("rstw");
        rst = 0;
        tick();
        chk("rstw_no_ack", rr_ack, 0);
        chk("rstw_idle", rr_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
